// File: rtl/bms_pkg.sv
// ----------------------------------------------------------------------------
// bms_pkg: shared constants, FSM encoding and frame helpers for the UART reporter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bms_pkg;

  localparam logic [7:0] HDR0        = 8'hA5;
  localparam logic [7:0] HDR1        = 8'h5A;
  localparam int         FRAME_BYTES = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Two's complement of the byte sum, so payload plus checksum sums to zero.
  function automatic logic [7:0] frame_checksum(input logic [79:0] snap);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < 10; i++) begin
      sum = sum + snap[8*i +: 8];
    end
    return ~sum + 8'd1;
  endfunction

  // Frame byte idx (2..11) taken from the snapshot, MSB-first per register.
  function automatic logic [7:0] snap_byte(input logic [79:0] snap, input logic [3:0] idx);
    logic [79:0] shifted;
    shifted = snap << (8 * (idx - 4'd2));
    return shifted[79:72];
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ----------------------------------------------------------------------------
// uart_tx_byte: 8N1 byte serializer with valid/ready handshake
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_byte
  import bms_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int              CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_q, tx_n;
  logic          baud_end;

  assign baud_end = (baud_cnt == LAST);
  // Ready in the final stop-bit cycle lets the next byte start with no idle gap.
  assign ready    = (state == IDLE) || ((state == STOP) && baud_end);
  assign tx       = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      tx_q     <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    tx_n       = tx_q;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (valid) begin
          state_n    = START;
          baud_cnt_n = '0;
          shreg_n    = data;
          tx_n       = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_n    = DATA;
          baud_cnt_n = '0;
          bit_idx_n  = 3'd0;
          tx_n       = shreg[0];
          shreg_n    = {1'b0, shreg[7:1]};
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shreg[0];
            shreg_n   = {1'b0, shreg[7:1]};
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          if (valid) begin
            state_n = START;
            shreg_n = data;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bms_uart_reporter.sv
// ----------------------------------------------------------------------------
// bms_uart_reporter: snapshots MAX17263 results and sends a 13-byte UART frame
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bms_uart_reporter
  import bms_pkg::*;
#(
  parameter int SYS_CLOCK = 100_000_000,
  parameter int BAUD      = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        measure_done,
  input  logic [15:0] fullcap,
  input  logic [15:0] repcap,
  input  logic [15:0] repsoc,
  input  logic [15:0] age,
  input  logic [15:0] thrmtemp,
  output logic        tx,
  output logic        busy,
  output logic        frame_drop
);

  localparam int         CLKS_PER_BIT = SYS_CLOCK / BAUD;
  localparam logic [3:0] LAST_BYTE    = 4'(FRAME_BYTES - 1);

  logic        done_d;
  logic        rise;
  logic        active;
  logic        drop_q;
  logic [3:0]  byte_idx;
  logic [3:0]  next_idx;
  logic [79:0] snap;
  logic [7:0]  csum;
  logic [7:0]  next_byte;
  logic        ser_valid;
  logic        ser_ready;

  assign rise       = measure_done & ~done_d;
  assign next_idx   = byte_idx + 4'd1;
  assign csum       = frame_checksum(snap);
  assign busy       = active;
  assign frame_drop = drop_q;

  // Byte 0 is launched in the accepting cycle, before the snapshot register loads.
  always_comb begin
    next_byte = HDR0;
    ser_valid = 1'b0;
    if (!active) begin
      next_byte = HDR0;
      ser_valid = rise;
    end else begin
      ser_valid = (byte_idx != LAST_BYTE);
      case (next_idx)
        4'd1:    next_byte = HDR1;
        4'd12:   next_byte = csum;
        default: next_byte = snap_byte(snap, next_idx);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_d   <= 1'b1;
      active   <= 1'b0;
      drop_q   <= 1'b0;
      byte_idx <= 4'd0;
      snap     <= 80'd0;
    end else begin
      done_d <= measure_done;
      drop_q <= rise & active;
      if (!active) begin
        if (rise) begin
          active   <= 1'b1;
          byte_idx <= 4'd0;
          snap     <= {fullcap, repcap, repsoc, age, thrmtemp};
        end
      end else if (ser_ready) begin
        // While active, ready only fires in a byte's final stop-bit cycle.
        if (byte_idx == LAST_BYTE) begin
          active <= 1'b0;
        end else begin
          byte_idx <= next_idx;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .valid (ser_valid),
    .data  (next_byte),
    .ready (ser_ready),
    .tx    (tx)
  );

endmodule

`default_nettype wire
